// File: rtl/id_issue_pkg.sv
// Shared decode constants for the ID stage: opcodes, funcs, ALU encodings and control bundle.
package id_issue_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;

  localparam logic [7:0] ALU_NOP = 8'b0000_0000;
  localparam logic [7:0] ALU_AND = 8'b0010_0100;
  localparam logic [7:0] ALU_OR  = 8'b0010_0101;
  localparam logic [7:0] ALU_XOR = 8'b0010_0110;
  localparam logic [7:0] ALU_NOR = 8'b0010_0111;
  localparam logic [7:0] ALU_SLL = 8'b0111_1100;
  localparam logic [7:0] ALU_SRL = 8'b0000_0010;
  localparam logic [7:0] ALU_SRA = 8'b0000_0011;
  localparam logic [7:0] ALU_LW  = 8'b1110_0011;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_LOAD  = 3'b111;

  localparam logic [4:0]  NOP_REG_ADDR = 5'd0;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

  // Operand shape of the decoded instruction; FMT_NONE doubles as "undefined".
  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_R,
    FMT_SHIMM,
    FMT_I,
    FMT_LUI
  } fmt_e;

  typedef struct packed {
    logic [7:0] aluop;
    logic [2:0] alusel;
    logic       wreg;
    logic [4:0] wd;
    logic       re1;
    logic       re2;
    logic       invalid;
  } ctrl_t;

endpackage

// File: rtl/id_issue_if.sv
// ID/EX pipeline register bundle; master drives it, the EX stage consumes it.
interface id_issue_if #(parameter int DATA_W = 32);
  logic              out_valid_o;
  logic              wreg_o;
  logic [4:0]        wd_o;
  logic [7:0]        aluop_o;
  logic [2:0]        alusel_o;
  logic [DATA_W-1:0] reg1_o;
  logic [DATA_W-1:0] reg2_o;
  logic [DATA_W-1:0] pc_o;
  logic              invalid_o;

  modport master (output out_valid_o, wreg_o, wd_o, aluop_o, alusel_o, reg1_o, reg2_o, pc_o, invalid_o);
  modport slave  (input  out_valid_o, wreg_o, wd_o, aluop_o, alusel_o, reg1_o, reg2_o, pc_o, invalid_o);
endinterface

// File: rtl/id_issue_decoder.sv
// Purely combinational instruction decode: control bundle, source addresses, immediate.
module id_decoder
  import id_issue_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [31:0]       inst_i,
  output ctrl_t             ctrl_o,
  output logic [4:0]        rs_o,
  output logic [4:0]        rt_o,
  output logic [DATA_W-1:0] imm_o
);

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, sh;
  logic [15:0] imm16;
  fmt_e        fmt;
  logic        sext;
  logic [7:0]  aluop;
  logic [2:0]  alusel;

  assign op    = inst_i[31:26];
  assign rs    = inst_i[25:21];
  assign rt    = inst_i[20:16];
  assign rd    = inst_i[15:11];
  assign sh    = inst_i[10:6];
  assign fn    = inst_i[5:0];
  assign imm16 = inst_i[15:0];
  assign rs_o  = rs;
  assign rt_o  = rt;

  always_comb begin
    fmt    = FMT_NONE;
    sext   = 1'b0;
    aluop  = ALU_NOP;
    alusel = SEL_NOP;
    case (op)
      OP_SPECIAL: begin
        case (fn)
          FN_OR:   begin fmt = FMT_R; aluop = ALU_OR;  alusel = SEL_LOGIC; end
          FN_AND:  begin fmt = FMT_R; aluop = ALU_AND; alusel = SEL_LOGIC; end
          FN_XOR:  begin fmt = FMT_R; aluop = ALU_XOR; alusel = SEL_LOGIC; end
          FN_NOR:  begin fmt = FMT_R; aluop = ALU_NOR; alusel = SEL_LOGIC; end
          FN_SLLV: begin fmt = FMT_R; aluop = ALU_SLL; alusel = SEL_SHIFT; end
          FN_SRLV: begin fmt = FMT_R; aluop = ALU_SRL; alusel = SEL_SHIFT; end
          FN_SRAV: begin fmt = FMT_R; aluop = ALU_SRA; alusel = SEL_SHIFT; end
          // Shift-by-shamt forms are only defined with rs == 0.
          FN_SLL: if (rs == NOP_REG_ADDR) begin fmt = FMT_SHIMM; aluop = ALU_SLL; alusel = SEL_SHIFT; end
          FN_SRL: if (rs == NOP_REG_ADDR) begin fmt = FMT_SHIMM; aluop = ALU_SRL; alusel = SEL_SHIFT; end
          FN_SRA: if (rs == NOP_REG_ADDR) begin fmt = FMT_SHIMM; aluop = ALU_SRA; alusel = SEL_SHIFT; end
          default: ;
        endcase
      end
      OP_ORI:  begin fmt = FMT_I;   aluop = ALU_OR;  alusel = SEL_LOGIC; end
      OP_ANDI: begin fmt = FMT_I;   aluop = ALU_AND; alusel = SEL_LOGIC; end
      OP_XORI: begin fmt = FMT_I;   aluop = ALU_XOR; alusel = SEL_LOGIC; end
      OP_LUI:  begin fmt = FMT_LUI; aluop = ALU_OR;  alusel = SEL_LOGIC; end
      OP_LW:   begin fmt = FMT_I;   aluop = ALU_LW;  alusel = SEL_LOAD; sext = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    ctrl_o.aluop   = aluop;
    ctrl_o.alusel  = alusel;
    ctrl_o.wreg    = (fmt != FMT_NONE);
    ctrl_o.invalid = (fmt == FMT_NONE);
    ctrl_o.re1     = (fmt == FMT_R) || (fmt == FMT_I);
    ctrl_o.re2     = (fmt == FMT_R) || (fmt == FMT_SHIMM);
    ctrl_o.wd      = NOP_REG_ADDR;
    if ((fmt == FMT_R) || (fmt == FMT_SHIMM)) begin
      ctrl_o.wd = rd;
    end else if ((fmt == FMT_I) || (fmt == FMT_LUI)) begin
      ctrl_o.wd = rt;
    end
    case (fmt)
      FMT_SHIMM: imm_o = DATA_W'(sh);
      FMT_I:     imm_o = sext ? DATA_W'($signed(imm16)) : DATA_W'(imm16);
      FMT_LUI:   imm_o = DATA_W'({imm16, 16'h0000});
      default:   imm_o = '0;
    endcase
  end

endmodule

// File: rtl/id_issue.sv
// ID stage: decode, operand forwarding, load-use hazard detection and the ID/EX register.
module id_issue
  import id_issue_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int FWD_SRCS = 2,
  parameter int LOAD_EN  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid_i,
  input  logic [DATA_W-1:0]          pc_i,
  input  logic [31:0]                inst_i,
  input  logic [DATA_W-1:0]          reg1_data_i,
  input  logic [DATA_W-1:0]          reg2_data_i,
  input  logic [FWD_SRCS-1:0]        fwd_we_i,
  input  logic [5*FWD_SRCS-1:0]      fwd_addr_i,
  input  logic [DATA_W*FWD_SRCS-1:0] fwd_data_i,
  input  logic                       ex_is_load_i,
  input  logic                       stall_i,
  input  logic                       flush_i,
  output logic [4:0]                 reg1_addr_o,
  output logic [4:0]                 reg2_addr_o,
  output logic                       reg1_read_o,
  output logic                       reg2_read_o,
  output logic                       stall_req_o,
  id_issue_if.master                 ex_o
);

  typedef struct packed {
    logic              vld;
    logic              wreg;
    logic [4:0]        wd;
    logic [7:0]        aluop;
    logic [2:0]        alusel;
    logic [DATA_W-1:0] reg1;
    logic [DATA_W-1:0] reg2;
    logic [DATA_W-1:0] pc;
    logic              invalid;
  } idex_t;

  localparam idex_t BUBBLE = '{vld: 1'b0, wreg: 1'b0, wd: NOP_REG_ADDR, aluop: ALU_NOP,
                               alusel: SEL_NOP, reg1: DATA_W'(ZERO_WORD),
                               reg2: DATA_W'(ZERO_WORD), pc: DATA_W'(ZERO_WORD),
                               invalid: 1'b0};

  ctrl_t             dec;
  logic [4:0]        rs, rt;
  logic [DATA_W-1:0] imm, op1, op2;
  logic [4:0]        ex_addr;
  logic              hazard;
  idex_t             idex_d, idex_q;

  id_decoder #(.DATA_W(DATA_W)) u_dec (
    .inst_i (inst_i),
    .ctrl_o (dec),
    .rs_o   (rs),
    .rt_o   (rt),
    .imm_o  (imm)
  );

  // Scanning from the oldest source down lets the youngest match win.
  function automatic logic [DATA_W-1:0] fwd_pick(
    input logic                       re,
    input logic [4:0]                 addr,
    input logic [DATA_W-1:0]          rf,
    input logic [DATA_W-1:0]          imm_v,
    input logic [FWD_SRCS-1:0]        we,
    input logic [5*FWD_SRCS-1:0]      faddr,
    input logic [DATA_W*FWD_SRCS-1:0] fdata
  );
    logic [DATA_W-1:0] v;
    v = rf;
    if (!re) begin
      v = imm_v;
    end else if (addr != NOP_REG_ADDR) begin
      for (int i = FWD_SRCS - 1; i >= 0; i--) begin
        if (we[i] && (faddr[i*5 +: 5] == addr)) v = fdata[i*DATA_W +: DATA_W];
      end
    end
    return v;
  endfunction

  assign op1 = fwd_pick(dec.re1, rs, reg1_data_i, imm, fwd_we_i, fwd_addr_i, fwd_data_i);
  assign op2 = fwd_pick(dec.re2, rt, reg2_data_i, imm, fwd_we_i, fwd_addr_i, fwd_data_i);

  assign reg1_addr_o = rs;
  assign reg2_addr_o = rt;
  assign reg1_read_o = dec.re1;
  assign reg2_read_o = dec.re2;

  assign ex_addr = fwd_addr_i[4:0];
  assign hazard  = (LOAD_EN != 0) && in_valid_i && ex_is_load_i && fwd_we_i[0] &&
                   (ex_addr != NOP_REG_ADDR) &&
                   ((dec.re1 && (ex_addr == rs)) || (dec.re2 && (ex_addr == rt)));
  assign stall_req_o = hazard && !flush_i;

  always_comb begin
    idex_d = BUBBLE;
    if (flush_i) begin
      idex_d = BUBBLE;
    end else if (stall_i) begin
      idex_d = idex_q;
    end else if (hazard) begin
      idex_d = BUBBLE;
    end else if (in_valid_i) begin
      idex_d.vld     = 1'b1;
      idex_d.wreg    = dec.wreg;
      idex_d.wd      = dec.wd;
      idex_d.aluop   = dec.aluop;
      idex_d.alusel  = dec.alusel;
      idex_d.reg1    = op1;
      idex_d.reg2    = op2;
      idex_d.pc      = pc_i;
      idex_d.invalid = dec.invalid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) idex_q <= BUBBLE;
    else     idex_q <= idex_d;
  end

  assign ex_o.out_valid_o = idex_q.vld;
  assign ex_o.wreg_o      = idex_q.wreg;
  assign ex_o.wd_o        = idex_q.wd;
  assign ex_o.aluop_o     = idex_q.aluop;
  assign ex_o.alusel_o    = idex_q.alusel;
  assign ex_o.reg1_o      = idex_q.reg1;
  assign ex_o.reg2_o      = idex_q.reg2;
  assign ex_o.pc_o        = idex_q.pc;
  assign ex_o.invalid_o   = idex_q.invalid;

endmodule

// File: tb/tb_id_issue.sv
// Scoreboard bench for id_issue: expected ID/EX contents are queued as stimulus is applied.
module tb_id_issue;
  import id_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] pc, inst, rd1, rd2;
  logic [1:0]  fwd_we;
  logic [9:0]  fwd_addr;
  logic [63:0] fwd_data;
  logic        ex_is_load, stall, flush;
  logic [4:0]  reg1_addr, reg2_addr;
  logic        reg1_read, reg2_read, stall_req;

  id_issue_if #(.DATA_W(32)) ex_if ();

  id_issue dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (in_valid),
    .pc_i         (pc),
    .inst_i       (inst),
    .reg1_data_i  (rd1),
    .reg2_data_i  (rd2),
    .fwd_we_i     (fwd_we),
    .fwd_addr_i   (fwd_addr),
    .fwd_data_i   (fwd_data),
    .ex_is_load_i (ex_is_load),
    .stall_i      (stall),
    .flush_i      (flush),
    .reg1_addr_o  (reg1_addr),
    .reg2_addr_o  (reg2_addr),
    .reg1_read_o  (reg1_read),
    .reg2_read_o  (reg2_read),
    .stall_req_o  (stall_req),
    .ex_o         (ex_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic        wreg;
    logic [4:0]  wd;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] pc;
    logic        inv;
  } exp_t;

  exp_t sb[$];
  exp_t held;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t bub();
    exp_t e;
    e = '{vld: 1'b0, wreg: 1'b0, wd: 5'd0, aluop: ALU_NOP, alusel: SEL_NOP,
          reg1: 32'h0, reg2: 32'h0, pc: 32'h0, inv: 1'b0};
    return e;
  endfunction

  function automatic exp_t mk(input logic wreg, input logic [4:0] wd, input logic [7:0] aluop,
                              input logic [2:0] alusel, input logic [31:0] r1,
                              input logic [31:0] r2, input logic [31:0] p, input logic inv);
    exp_t e;
    e = '{vld: 1'b1, wreg: wreg, wd: wd, aluop: aluop, alusel: alusel,
          reg1: r1, reg2: r2, pc: p, inv: inv};
    return e;
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {OP_SPECIAL, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic drv(input logic v, input logic [31:0] p, input logic [31:0] i,
                     input logic [31:0] d1, input logic [31:0] d2);
    in_valid = v; pc = p; inst = i; rd1 = d1; rd2 = d2;
  endtask

  task automatic fwd(input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
                     input logic [4:0] a1, input logic [31:0] d1);
    fwd_we = we; fwd_addr = {a1, a0}; fwd_data = {d1, d0};
  endtask

  // Queue the expected ID/EX contents, cross one rising edge, then compare at the falling edge.
  task automatic step(input string tag, input exp_t e);
    exp_t g;
    sb.push_back(e);
    held = e;
    @(negedge clk);
    if (sb.size() == 0) begin
      chk({tag, ".sb"}, 64'd0, 64'd1);
    end else begin
      g = sb.pop_front();
      chk({tag, ".vld"},    ex_if.out_valid_o, g.vld);
      chk({tag, ".wreg"},   ex_if.wreg_o,      g.wreg);
      chk({tag, ".wd"},     ex_if.wd_o,        g.wd);
      chk({tag, ".aluop"},  ex_if.aluop_o,     g.aluop);
      chk({tag, ".alusel"}, ex_if.alusel_o,    g.alusel);
      chk({tag, ".reg1"},   ex_if.reg1_o,      g.reg1);
      chk({tag, ".reg2"},   ex_if.reg2_o,      g.reg2);
      chk({tag, ".pc"},     ex_if.pc_o,        g.pc);
      chk({tag, ".inv"},    ex_if.invalid_o,   g.inv);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; ex_is_load = 1'b0;
    drv(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    fwd(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    @(negedge clk);

    // Reset state
    #1 chk("rst.stall_req", stall_req, 1'b0);
    step("rst0", bub());
    step("rst1", bub());
    rst = 1'b0;

    // ORI r2 = r1 | 0x00FF
    drv(1'b1, 32'h100, itype(OP_ORI, 5'd1, 5'd2, 16'h00FF), 32'h1234_0000, 32'hDEAD_BEEF);
    #1 chk("ori.addr1", reg1_addr, 5'd1);
    chk("ori.re1", reg1_read, 1'b1);
    chk("ori.re2", reg2_read, 1'b0);
    step("ori", mk(1'b1, 5'd2, ALU_OR, SEL_LOGIC, 32'h1234_0000, 32'h0000_00FF, 32'h100, 1'b0));

    // OR r3 = r1 | r2 with forwarding priority
    drv(1'b1, 32'h104, rtype(5'd1, 5'd2, 5'd3, 5'd0, FN_OR), 32'h11, 32'h22);
    fwd(2'b11, 5'd1, 32'hA, 5'd2, 32'hC);
    #1 chk("or.addr2", reg2_addr, 5'd2);
    step("or_fwd_a", mk(1'b1, 5'd3, ALU_OR, SEL_LOGIC, 32'hA, 32'hC, 32'h104, 1'b0));
    fwd(2'b11, 5'd1, 32'hA, 5'd1, 32'hB);
    step("or_fwd_young", mk(1'b1, 5'd3, ALU_OR, SEL_LOGIC, 32'hA, 32'h22, 32'h104, 1'b0));
    fwd(2'b10, 5'd1, 32'hA, 5'd1, 32'hB);
    step("or_fwd_old", mk(1'b1, 5'd3, ALU_OR, SEL_LOGIC, 32'hB, 32'h22, 32'h104, 1'b0));

    // Load-use hazard on r5, then release
    drv(1'b1, 32'h108, rtype(5'd5, 5'd7, 5'd6, 5'd0, FN_OR), 32'h50, 32'h77);
    fwd(2'b01, 5'd5, 32'h55, 5'd0, 32'h0);
    ex_is_load = 1'b1;
    #1 chk("lu.stall_req", stall_req, 1'b1);
    step("lu_bubble", bub());
    ex_is_load = 1'b0;
    #1 chk("lu.release", stall_req, 1'b0);
    step("lu_capture", mk(1'b1, 5'd6, ALU_OR, SEL_LOGIC, 32'h55, 32'h77, 32'h108, 1'b0));

    // Load targets rt of an I-type: rt is not read, no stall
    drv(1'b1, 32'h10C, itype(OP_ORI, 5'd7, 5'd5, 16'h0001), 32'h70, 32'h99);
    ex_is_load = 1'b1;
    #1 chk("lu_rt.stall_req", stall_req, 1'b0);
    step("lu_rt", mk(1'b1, 5'd5, ALU_OR, SEL_LOGIC, 32'h70, 32'h1, 32'h10C, 1'b0));

    // $0 is never forwarded nor a hazard
    drv(1'b1, 32'h110, rtype(5'd0, 5'd0, 5'd3, 5'd0, FN_OR), 32'h0, 32'h0);
    fwd(2'b11, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFF);
    #1 chk("r0.stall_req", stall_req, 1'b0);
    step("r0", mk(1'b1, 5'd3, ALU_OR, SEL_LOGIC, 32'h0, 32'h0, 32'h110, 1'b0));
    ex_is_load = 1'b0;
    fwd(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);

    // Hold for three cycles, hazard coinciding with hold, then flush
    drv(1'b1, 32'h114, itype(OP_XORI, 5'd1, 5'd4, 16'hF0F0), 32'h0F0F_0000, 32'h0);
    step("xori", mk(1'b1, 5'd4, ALU_XOR, SEL_LOGIC, 32'h0F0F_0000, 32'h0000_F0F0, 32'h114, 1'b0));
    stall = 1'b1;
    drv(1'b1, 32'h118, rtype(5'd8, 5'd9, 5'd10, 5'd0, FN_AND), 32'h1, 32'h2);
    step("hold0", held);
    fwd(2'b01, 5'd8, 32'h3, 5'd0, 32'h0);
    ex_is_load = 1'b1;
    #1 chk("hold.stall_req", stall_req, 1'b1);
    step("hold1", held);
    drv(1'b0, 32'h11C, 32'h0, 32'h5, 32'h6);
    step("hold2", held);
    drv(1'b1, 32'h118, rtype(5'd8, 5'd9, 5'd10, 5'd0, FN_AND), 32'h1, 32'h2);
    flush = 1'b1;
    #1 chk("flush.stall_req", stall_req, 1'b0);
    step("flush", bub());
    stall = 1'b0; flush = 1'b0; ex_is_load = 1'b0;
    fwd(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);

    // Undefined opcode, then reset
    drv(1'b1, 32'h120, 32'hFC00_0000, 32'h1234, 32'h5678);
    #1 chk("inv.re1", reg1_read, 1'b0);
    chk("inv.re2", reg2_read, 1'b0);
    step("inv", mk(1'b0, 5'd0, ALU_NOP, SEL_NOP, 32'h0, 32'h0, 32'h120, 1'b1));
    rst = 1'b1;
    drv(1'b1, 32'h124, itype(OP_ORI, 5'd1, 5'd2, 16'h1), 32'h1, 32'h0);
    step("inv_rst", bub());
    rst = 1'b0;

    // Shift by shamt: reg1 = shamt, reg2 = rt operand
    drv(1'b1, 32'h128, rtype(5'd0, 5'd3, 5'd4, 5'd5, FN_SRA), 32'h999, 32'h8000_0000);
    #1 chk("sra.re1", reg1_read, 1'b0);
    step("sra", mk(1'b1, 5'd4, ALU_SRA, SEL_SHIFT, 32'h5, 32'h8000_0000, 32'h128, 1'b0));
    drv(1'b1, 32'h12C, rtype(5'd1, 5'd3, 5'd4, 5'd2, FN_SLL), 32'h1, 32'h2);
    step("sll_rs", mk(1'b0, 5'd0, ALU_NOP, SEL_NOP, 32'h0, 32'h0, 32'h12C, 1'b1));
    drv(1'b1, 32'h130, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'b100000), 32'h1, 32'h2);
    step("bad_fn", mk(1'b0, 5'd0, ALU_NOP, SEL_NOP, 32'h0, 32'h0, 32'h130, 1'b1));

    // LUI, LW sign extension, NOR, SRLV
    drv(1'b1, 32'h134, itype(OP_LUI, 5'd3, 5'd9, 16'h1234), 32'hAAAA, 32'hBBBB);
    step("lui", mk(1'b1, 5'd9, ALU_OR, SEL_LOGIC, 32'h1234_0000, 32'h1234_0000, 32'h134, 1'b0));
    drv(1'b1, 32'h138, itype(OP_LW, 5'd1, 5'd8, 16'hFFF0), 32'h1000, 32'h0);
    step("lw", mk(1'b1, 5'd8, ALU_LW, SEL_LOAD, 32'h1000, 32'hFFFF_FFF0, 32'h138, 1'b0));
    drv(1'b1, 32'h13C, itype(OP_ANDI, 5'd1, 5'd8, 16'h8001), 32'hFFFF_FFFF, 32'h0);
    step("andi", mk(1'b1, 5'd8, ALU_AND, SEL_LOGIC, 32'hFFFF_FFFF, 32'h0000_8001, 32'h13C, 1'b0));
    drv(1'b1, 32'h140, rtype(5'd1, 5'd2, 5'd3, 5'd0, FN_NOR), 32'hF0, 32'h0F);
    step("nor", mk(1'b1, 5'd3, ALU_NOR, SEL_LOGIC, 32'hF0, 32'h0F, 32'h140, 1'b0));
    drv(1'b1, 32'h144, rtype(5'd4, 5'd6, 5'd7, 5'd0, FN_SRLV), 32'h4, 32'h100);
    step("srlv", mk(1'b1, 5'd7, ALU_SRL, SEL_SHIFT, 32'h4, 32'h100, 32'h144, 1'b0));

    // No instruction presented -> bubble
    drv(1'b0, 32'h148, rtype(5'd1, 5'd2, 5'd3, 5'd0, FN_OR), 32'h1, 32'h2);
    step("idle", bub());

    // Reset during a hold discards the held instruction
    drv(1'b1, 32'h14C, itype(OP_ORI, 5'd1, 5'd2, 16'h0003), 32'h10, 32'h0);
    step("pre_hold", mk(1'b1, 5'd2, ALU_OR, SEL_LOGIC, 32'h10, 32'h3, 32'h14C, 1'b0));
    stall = 1'b1; rst = 1'b1;
    step("rst_hold", bub());
    rst = 1'b0;
    step("post_rst_hold", bub());
    stall = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_issue.md
ID_ISSUE -- requirements
Module: id_issue

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set operand/PC/forward data width.
REQ-002 Parameter FWD_SRCS, default 2, SHALL set number of forwarding sources; index 0 = youngest (EX), rising index = older.
REQ-003 Parameter LOAD_EN, default 1, SHALL enable load-use stall detection when 1; when 0, stall_req_o is tied 0.
REQ-004 clk  in  1  single clock, all state rising-edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 in_valid_i  in  1  IF/ID carries an instruction.
REQ-007 pc_i  in  DATA_W  instruction PC; inst_i  in  32  instruction word.
REQ-008 reg1_data_i, reg2_data_i  in  DATA_W  regfile read data.
REQ-009 fwd_we_i  in  FWD_SRCS  per-source write enable; fwd_addr_i  in  5*FWD_SRCS  dest addresses; fwd_data_i  in  DATA_W*FWD_SRCS  result data.
REQ-010 ex_is_load_i  in  1  source 0 is a load (data not yet available).
REQ-011 stall_i  in  1  downstream hold; flush_i  in  1  discard ID/EX contents.
REQ-012 reg1_addr_o, reg2_addr_o  out  5  combinational regfile addresses (rs, rt); reg1_read_o, reg2_read_o  out  1  combinational read enables.
REQ-013 stall_req_o  out  1  combinational load-use stall request to IF/ID.
REQ-014 out_valid_o, wreg_o  out  1; wd_o  out  5; aluop_o  out  8; alusel_o  out  3; reg1_o, reg2_o, pc_o  out  DATA_W  -- registered ID/EX outputs.
REQ-015 invalid_o  out  1  registered: captured instruction had undefined opcode/func.

Function
REQ-016 Decode SHALL support OR, AND, XOR, NOR, SLLV, SRLV, SRAV, SLL, SRL, SRA (rs==0 required), ORI, ANDI, XORI, LUI, LW.
- R-type: both reads, wd=rd; I-type: rs read, wd=rt; LUI: no reads, wd=rt.
REQ-017 Immediates: ORI/ANDI/XORI zero-extend; LW sign-extends; LUI = imm<<16; shift-immediate: reg1_o = shamt zero-extended, reg2_o = rt operand.
REQ-018 Operand per port: read disabled -> immediate; else lowest-index source with fwd_we_i=1 and matching nonzero addr; else regfile data.
REQ-019 Address 0 SHALL never be forwarded; operand for $0 is regfile data.
REQ-020 Undefined opcode/func SHALL decode as NOP (aluop/alusel NOP, wreg=0, no reads) with invalid flag 1.
REQ-021 Load-use hazard = LOAD_EN & in_valid_i & ex_is_load_i & fwd_we_i[0] & fwd_addr[0]!=0 & matches an enabled read address; stall_req_o = hazard & ~flush_i.
REQ-022 ID/EX register update priority per cycle: rst > flush_i > stall_i (hold all) > hazard (bubble) > in_valid_i (capture decoded) > bubble.
REQ-023 Bubble: out_valid_o=0, wreg_o=0, wd_o=0, aluop/alusel NOP, reg1_o=reg2_o=0, pc_o=0, invalid_o=0.
REQ-024 Latency: instruction accepted in cycle N appears on outputs in cycle N+1.
REQ-025 stall_i and hazard together: hold wins; stall_req_o still asserted.

Reset
REQ-026 rst SHALL force bubble state (REQ-023) at next edge; reset mid-stall discards held instruction.
REQ-027 Combinational outputs carry no state; no reset dependency beyond inputs.

Structure
REQ-028 Shared package SHALL hold opcode/func constants, aluop/alusel encodings, NOP register address, zero word.
REQ-029 Combinational decode SHALL be sub-module id_decoder (inst -> control, addresses, immediate, invalid); forwarding, hazard and ID/EX register live in id_issue.

Verification
REQ-030 ORI r2=r1|0x00FF, r1=0x12340000, no fwd -> next cycle reg1_o=0x12340000, reg2_o=0x000000FF, wd_o=2, wreg_o=1.
REQ-031 OR r3=r1|r2 with fwd0(addr1,0xA) and fwd1(addr1,0xB), fwd1(addr2,0xC) -> reg1_o=0xA, reg2_o=0xC.
REQ-032 LW to r5 in EX (ex_is_load_i=1), ID ADD-type reading r5 -> stall_req_o=1, next out_valid_o=0; drop load flag -> instruction captured.
REQ-033 Forward to addr 0 with data 0xFFFFFFFF, instruction reads $0, regfile 0 -> reg1_o=0.
REQ-034 stall_i=1 with valid instruction held 3 cycles then flush_i=1 -> outputs unchanged 3 cycles, then bubble.
REQ-035 inst_i=0xFC000000 -> invalid_o=1, wreg_o=0, out_valid_o=1; rst asserted next -> all outputs bubble.
